// File: rtl/rotor_step_ctrl.sv
// Rotor configuration and stepping controller: latches rotor selection/positions,
// advances the rotors per letter (notch plus double-step) and forwards each letter downstream.
module rotor_step_ctrl #(
    parameter int NUM_POS = 26
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rotor_valid_in,
    input  logic        letter_valid_in,
    input  logic [8:0]  rotor_select_in,
    input  logic [14:0] rotor_initial_in,
    input  logic [4:0]  char_in,
    input  logic        enc_ready_in,
    output logic        ready_out,
    output logic [8:0]  sel_out,
    output logic [14:0] pos_out,
    output logic [4:0]  char_out,
    output logic        char_valid_out,
    output logic        err_out
);

    typedef enum logic [1:0] {IDLE, LOAD, STEP, EMIT} state_t;

    state_t      state_q, state_d;
    logic [8:0]  sel_q, sel_d;
    logic [14:0] pos_q, pos_d;
    logic [8:0]  cfg_sel_q, cfg_sel_d;
    logic [14:0] cfg_pos_q, cfg_pos_d;
    logic [4:0]  char_q, char_d;
    logic        err_q, err_d;

    logic        letter_ok;
    logic        r_notch, m_notch;

    function automatic logic [4:0] wrap_pos(input logic [4:0] p);
        if (p >= 5'(NUM_POS)) return p - 5'(NUM_POS);
        return p;
    endfunction

    function automatic logic [4:0] inc_pos(input logic [4:0] p);
        if (p == 5'(NUM_POS - 1)) return 5'd0;
        return p + 5'd1;
    endfunction

    // Rotors VI..VIII carry two notches (Z and M); the rest carry one.
    function automatic logic at_notch(input logic [2:0] id, input logic [4:0] p);
        case (id)
            3'd0:    return p == 5'd16;
            3'd1:    return p == 5'd4;
            3'd2:    return p == 5'd21;
            3'd3:    return p == 5'd9;
            3'd4:    return p == 5'd25;
            default: return (p == 5'd25) || (p == 5'd12);
        endcase
    endfunction

    assign letter_ok = char_in <= 5'(NUM_POS - 1);
    assign r_notch   = at_notch(sel_q[2:0], pos_q[4:0]);
    assign m_notch   = at_notch(sel_q[5:3], pos_q[9:5]);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            pos_q     <= '0;
            cfg_sel_q <= '0;
            cfg_pos_q <= '0;
            char_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            pos_q     <= pos_d;
            cfg_sel_q <= cfg_sel_d;
            cfg_pos_q <= cfg_pos_d;
            char_q    <= char_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rotor_valid_in)                    state_d = LOAD;
                else if (letter_valid_in && letter_ok) state_d = STEP;
            end
            LOAD:    state_d = IDLE;
            STEP:    state_d = EMIT;
            EMIT:    if (enc_ready_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Register updates; a config strobe in IDLE overrides a simultaneous letter.
    always_comb begin
        sel_d     = sel_q;
        pos_d     = pos_q;
        cfg_sel_d = cfg_sel_q;
        cfg_pos_d = cfg_pos_q;
        char_d    = char_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rotor_valid_in) begin
                    cfg_sel_d = rotor_select_in;
                    cfg_pos_d = rotor_initial_in;
                end else if (letter_valid_in) begin
                    if (letter_ok) char_d = char_in;
                    else           err_d  = 1'b1;
                end
            end
            LOAD: begin
                sel_d = cfg_sel_q;
                pos_d = {wrap_pos(cfg_pos_q[14:10]), wrap_pos(cfg_pos_q[9:5]),
                         wrap_pos(cfg_pos_q[4:0])};
            end
            STEP: begin
                pos_d[4:0] = inc_pos(pos_q[4:0]);
                if (r_notch || m_notch) pos_d[9:5]   = inc_pos(pos_q[9:5]);
                if (m_notch)            pos_d[14:10] = inc_pos(pos_q[14:10]);
            end
            default: ;
        endcase
    end

    always_comb begin
        ready_out      = (state_q == IDLE);
        char_valid_out = (state_q == EMIT);
        sel_out        = sel_q;
        pos_out        = pos_q;
        char_out       = char_q;
        err_out        = err_q;
    end

endmodule

// File: tb/tb_rotor_step_ctrl.sv
// Scoreboard bench for rotor_step_ctrl: directed configs/letters with hand-computed positions.
module tb_rotor_step_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rotor_valid = 1'b0;
    logic        letter_valid = 1'b0;
    logic [8:0]  rsel = '0;
    logic [14:0] rinit = '0;
    logic [4:0]  chr = '0;
    logic        enc_ready = 1'b1;
    logic        ready_out, char_valid_out, err_out;
    logic [8:0]  sel_out;
    logic [14:0] pos_out;
    logic [4:0]  char_out;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_e;

    rotor_step_ctrl #(.NUM_POS(26)) dut (
        .clk_in(clk), .rst_in(rst), .rotor_valid_in(rotor_valid),
        .letter_valid_in(letter_valid), .rotor_select_in(rsel),
        .rotor_initial_in(rinit), .char_in(chr), .enc_ready_in(enc_ready),
        .ready_out(ready_out), .sel_out(sel_out), .pos_out(pos_out),
        .char_out(char_out), .char_valid_out(char_valid_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] p3(input int l, input int m, input int r);
        return {5'(l), 5'(m), 5'(r)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per accepted output.
    always @(negedge clk) begin
        if (!rst && char_valid_out && enc_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got char %0d pos %h expected none", char_out, pos_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("emit_char", int'(char_out), int'(mon_e[19:15]));
                check("emit_pos", int'(pos_out), int'(mon_e[14:0]));
            end
        end
    end

    task automatic idle_wait();
        int k = 0;
        while (!ready_out && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!ready_out) check("idle_timeout", 0, 1);
    endtask

    task automatic cv_wait();
        int k = 0;
        while (!char_valid_out && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!char_valid_out) check("valid_timeout", 0, 1);
    endtask

    task automatic do_config(input logic [8:0] s, input logic [14:0] p, input logic [14:0] e);
        idle_wait();
        @(posedge clk); #1;
        rotor_valid = 1'b1; rsel = s; rinit = p;
        @(posedge clk); #1;
        rotor_valid = 1'b0;
        check("load_ready_low", int'(ready_out), 0);
        @(posedge clk); #1;
        check("cfg_sel", int'(sel_out), int'(s));
        check("cfg_pos", int'(pos_out), int'(e));
    endtask

    task automatic do_letter(input logic [4:0] c, input logic [14:0] e, input bit push);
        idle_wait();
        @(posedge clk); #1;
        letter_valid = 1'b1; chr = c;
        if (push) exp_q.push_back({c, e});
        @(posedge clk); #1;
        letter_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", int'(ready_out), 1);
        check("rst_pos", int'(pos_out), 0);
        check("rst_sel", int'(sel_out), 0);
        check("rst_valid", int'(char_valid_out), 0);
        check("rst_err", int'(err_out), 0);
        rst = 1'b0;

        // I,II,III at A,D,V: right notch, then mid double-step
        do_config(9'b000_001_010, p3(0, 3, 21), p3(0, 3, 21));
        do_letter(5'd0, p3(0, 4, 22), 1'b1);
        do_letter(5'd7, p3(1, 5, 23), 1'b1);

        // Right wrap without notches; out-of-range initial positions reduced
        do_config(9'b000_001_010, p3(0, 0, 25), p3(0, 0, 25));
        do_letter(5'd4, p3(0, 0, 0), 1'b1);
        do_config(9'b000_001_010, p3(31, 0, 30), p3(5, 0, 4));
        do_letter(5'd10, p3(5, 0, 5), 1'b1);

        // Rotor VI second notch (M) on the right; VIII Z notch on the mid
        do_config(9'b000_000_101, p3(0, 0, 12), p3(0, 0, 12));
        do_letter(5'd12, p3(0, 1, 13), 1'b1);
        do_config(9'b000_111_000, p3(3, 25, 0), p3(3, 25, 0));
        do_letter(5'd25, p3(4, 0, 1), 1'b1);

        // Backpressure with an ignored letter strobe
        idle_wait();
        @(posedge clk); #1;
        enc_ready = 1'b0;
        do_letter(5'd20, p3(4, 0, 2), 1'b1);
        cv_wait();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", int'(char_valid_out), 1);
            check("bp_char", int'(char_out), 20);
            check("bp_ready", int'(ready_out), 0);
            #1;
            letter_valid = (i == 1);
            chr = 5'd3;
        end
        letter_valid = 1'b0;
        @(posedge clk); #1;
        enc_ready = 1'b1;
        idle_wait();
        repeat (3) @(posedge clk);
        #1;
        check("bp_pos_after", int'(pos_out), int'(p3(4, 0, 2)));

        // Illegal letter: one-cycle err pulse, no step
        do_letter(5'd27, '0, 1'b0);
        check("err_pulse", int'(err_out), 1);
        check("err_ready", int'(ready_out), 1);
        @(posedge clk); #1;
        check("err_clear", int'(err_out), 0);
        check("err_pos", int'(pos_out), int'(p3(4, 0, 2)));

        // Collision: config wins, letter dropped silently
        idle_wait();
        @(posedge clk); #1;
        rotor_valid = 1'b1; letter_valid = 1'b1; chr = 5'd5;
        rsel = 9'b000_001_010; rinit = p3(1, 2, 3);
        @(posedge clk); #1;
        rotor_valid = 1'b0; letter_valid = 1'b0;
        check("coll_err", int'(err_out), 0);
        @(posedge clk); #1;
        check("coll_pos", int'(pos_out), int'(p3(1, 2, 3)));
        check("coll_sel", int'(sel_out), 9'b000_001_010);
        repeat (4) @(posedge clk);
        #1;
        check("coll_pos_hold", int'(pos_out), int'(p3(1, 2, 3)));

        // Async reset during EMIT
        enc_ready = 1'b0;
        do_letter(5'd9, '0, 1'b0);
        cv_wait();
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_ready", int'(ready_out), 1);
        check("arst_valid", int'(char_valid_out), 0);
        check("arst_pos", int'(pos_out), 0);
        check("arst_sel", int'(sel_out), 0);
        check("arst_char", int'(char_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        enc_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("arst_valid_after", int'(char_valid_out), 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
